// File: rtl/ddr_rd_arb_if.sv
// Request and AXI read-channel bundle shared by the two-port DDR read arbiter.
// The master modport is the arbiter's view; slave is the requester/memory side.
interface ddr_rd_arb_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int P_DDR_LOCAL_QUEUE  = 4
);
  logic [P_DDR_LOCAL_QUEUE-1:0]  i_port0_rd_queue;
  logic [C_M_AXI_ADDR_WIDTH-1:0] i_port0_rd_byte;
  logic                          i_port0_rd_valid;
  logic                          o_port0_rd_ready;
  logic                          o_port0_rd_done;

  logic [P_DDR_LOCAL_QUEUE-1:0]  i_port1_rd_queue;
  logic [C_M_AXI_ADDR_WIDTH-1:0] i_port1_rd_byte;
  logic                          i_port1_rd_valid;
  logic                          o_port1_rd_ready;
  logic                          o_port1_rd_done;

  logic [C_M_AXI_ADDR_WIDTH-1:0] o_m_axi_araddr;
  logic [7:0]                    o_m_axi_arlen;
  logic                          o_m_axi_arvalid;
  logic                          i_m_axi_arready;
  logic                          i_m_axi_rvalid;
  logic                          i_m_axi_rlast;
  logic                          o_m_axi_rready;

  logic                          o_rd_owner;
  logic                          o_rd_busy;

  modport master (
    input  i_port0_rd_queue, i_port0_rd_byte, i_port0_rd_valid,
    output o_port0_rd_ready, o_port0_rd_done,
    input  i_port1_rd_queue, i_port1_rd_byte, i_port1_rd_valid,
    output o_port1_rd_ready, o_port1_rd_done,
    output o_m_axi_araddr, o_m_axi_arlen, o_m_axi_arvalid,
    input  i_m_axi_arready, i_m_axi_rvalid, i_m_axi_rlast,
    output o_m_axi_rready,
    output o_rd_owner, o_rd_busy
  );

  modport slave (
    output i_port0_rd_queue, i_port0_rd_byte, i_port0_rd_valid,
    input  o_port0_rd_ready, o_port0_rd_done,
    output i_port1_rd_queue, i_port1_rd_byte, i_port1_rd_valid,
    input  o_port1_rd_ready, o_port1_rd_done,
    input  o_m_axi_araddr, o_m_axi_arlen, o_m_axi_arvalid,
    output i_m_axi_arready, i_m_axi_rvalid, i_m_axi_rlast,
    input  o_m_axi_rready,
    input  o_rd_owner, o_rd_busy
  );
endinterface

// File: rtl/ddr_rd_arb.sv
// Two-port round-robin DDR read arbiter: splits each request into 4 KB-safe AXI
// bursts against a per-queue wrapping read pointer, one burst outstanding at a time.
module ddr_rd_arb #(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          P_DDR_LOCAL_QUEUE  = 4,
  parameter logic [31:0] P_QUEUE_SPAN       = 32'h0010_0000,
  parameter int          P_BEAT_BYTES       = 64,
  parameter int          P_MAX_BURST        = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  ddr_rd_arb_if.master     bus
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int NQ = P_DDR_LOCAL_QUEUE;
  localparam int QW = (NQ > 1) ? $clog2(NQ) : 1;
  localparam logic [AW-1:0] BEAT = AW'(P_BEAT_BYTES);
  localparam logic [AW-1:0] SPAN = AW'(P_QUEUE_SPAN);
  localparam logic [AW-1:0] MAXB = AW'(P_MAX_BURST);
  localparam logic [AW-1:0] PAGE = AW'(4096);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state, w_next_state;
  logic            r_last_grant;
  logic            r_owner;
  logic [QW-1:0]   r_qidx;
  logic [AW-1:0]   r_remaining;
  logic [AW-1:0]   r_beats;
  logic [AW-1:0]   r_rd_ptr [NQ];

  logic            w_grant_sel;
  logic            w_accept;
  logic [NQ-1:0]   w_req_queue;
  logic [AW-1:0]   w_req_byte;
  logic [QW-1:0]   w_req_qidx;
  logic [AW-1:0]   w_req_beats;
  logic [AW-1:0]   w_cur_ptr;
  logic [AW-1:0]   w_to_4k;
  logic [AW-1:0]   w_burst;
  logic [AW-1:0]   w_ptr_sum;
  logic [AW-1:0]   w_ptr_next;
  logic            w_ar_fire;
  logic            w_r_last;

  // Both valid: the port not granted last wins; otherwise whichever is valid.
  always_comb begin
    if (bus.i_port0_rd_valid && bus.i_port1_rd_valid) w_grant_sel = ~r_last_grant;
    else                                              w_grant_sel = ~bus.i_port0_rd_valid;
  end

  assign w_accept    = (r_state == S_IDLE) && !i_rst &&
                       (bus.i_port0_rd_valid || bus.i_port1_rd_valid);
  assign w_req_queue = w_grant_sel ? bus.i_port1_rd_queue : bus.i_port0_rd_queue;
  assign w_req_byte  = w_grant_sel ? bus.i_port1_rd_byte  : bus.i_port0_rd_byte;
  assign w_req_beats = (w_req_byte / BEAT) + (((w_req_byte % BEAT) != '0) ? AW'(1) : AW'(0));

  always_comb begin
    w_req_qidx = '0;
    for (int i = NQ - 1; i >= 0; i--) begin
      if (w_req_queue[i]) w_req_qidx = QW'(i);
    end
  end

  assign w_cur_ptr = r_rd_ptr[r_qidx];
  assign w_to_4k   = (PAGE - {{(AW-12){1'b0}}, w_cur_ptr[11:0]}) / BEAT;

  always_comb begin
    w_burst = r_remaining;
    if (w_burst > MAXB)    w_burst = MAXB;
    if (w_burst > w_to_4k) w_burst = w_to_4k;
  end

  // Bursts never cross 4 KB and the span is 4 KB aligned, so one subtraction wraps.
  assign w_ptr_sum  = w_cur_ptr + r_beats * BEAT;
  assign w_ptr_next = (w_ptr_sum >= SPAN) ? (w_ptr_sum - SPAN) : w_ptr_sum;

  assign w_ar_fire = bus.o_m_axi_arvalid && bus.i_m_axi_arready;
  assign w_r_last  = (r_state == S_DATA) && bus.i_m_axi_rvalid && bus.i_m_axi_rlast;

  // A zero-byte request passes through ADDR without raising arvalid.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_ADDR;
      S_ADDR: begin
        if (r_remaining == '0) w_next_state = S_DONE;
        else if (w_ar_fire)    w_next_state = S_DATA;
      end
      S_DATA: begin
        if (w_r_last) w_next_state = ((r_remaining - r_beats) != '0) ? S_ADDR : S_DONE;
      end
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_qidx       <= '0;
      r_remaining  <= '0;
      r_beats      <= '0;
      for (int i = 0; i < NQ; i++) r_rd_ptr[i] <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_last_grant <= w_grant_sel;
        r_owner      <= w_grant_sel;
        r_qidx       <= w_req_qidx;
        r_remaining  <= w_req_beats;
      end
      if ((r_state == S_ADDR) && w_ar_fire) r_beats <= w_burst;
      // Early rlast still retires the full programmed burst.
      if (w_r_last) begin
        r_remaining      <= r_remaining - r_beats;
        r_rd_ptr[r_qidx] <= w_ptr_next;
      end
    end
  end

  assign bus.o_m_axi_arvalid  = (r_state == S_ADDR) && (r_remaining != '0);
  assign bus.o_m_axi_araddr   = bus.o_m_axi_arvalid ? (AW'(r_qidx) * SPAN + w_cur_ptr) : '0;
  assign bus.o_m_axi_arlen    = bus.o_m_axi_arvalid ? (w_burst[7:0] - 8'd1) : 8'd0;
  assign bus.o_m_axi_rready   = (r_state == S_DATA);

  assign bus.o_port0_rd_ready = w_accept && !w_grant_sel;
  assign bus.o_port1_rd_ready = w_accept &&  w_grant_sel;
  assign bus.o_port0_rd_done  = (r_state == S_DONE) && !r_owner;
  assign bus.o_port1_rd_done  = (r_state == S_DONE) &&  r_owner;
  assign bus.o_rd_owner       = w_accept ? w_grant_sel : r_owner;
  assign bus.o_rd_busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_ddr_rd_arb.sv
// Directed bench for ddr_rd_arb: requester/AXI-slave engine plus a scripted sequence
// with hand-computed addresses, lengths, grant order and done timing.
module tb_ddr_rd_arb;
  localparam int AW = 32;
  localparam int NQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr_rd_arb_if #(.C_M_AXI_ADDR_WIDTH(AW), .P_DDR_LOCAL_QUEUE(NQ)) bus ();

  ddr_rd_arb #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .P_DDR_LOCAL_QUEUE (NQ),
    .P_QUEUE_SPAN      (32'h0010_0000),
    .P_BEAT_BYTES      (64),
    .P_MAX_BURST       (64)
  ) u_dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;

  int            req_left [2];
  logic [NQ-1:0] q_sel    [2];
  logic [AW-1:0] q_bytes  [2];
  int            ar_hold, r_left;

  logic [AW-1:0] ar_addr_q [$];
  logic [7:0]    ar_len_q  [$];
  int            grant_q   [$];
  int            done_cnt  [2];
  int            grant_cyc, last_cyc, done_cyc;
  int            beats_rcvd, arvalid_seen, ar_stall, ar_unstable;
  logic          ar_wait;
  logic [AW-1:0] ar_ref_addr;
  logic [7:0]    ar_ref_len;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic clear_logs();
    ar_addr_q.delete();
    ar_len_q.delete();
    grant_q.delete();
    done_cnt[0] = 0; done_cnt[1] = 0;
    beats_rcvd = 0; arvalid_seen = 0; ar_stall = 0; ar_unstable = 0;
  endtask

  task automatic issue(input int port, input logic [NQ-1:0] q, input logic [AW-1:0] bytes);
    q_sel[port]    = q;
    q_bytes[port]  = bytes;
    req_left[port] = 1;
  endtask

  task automatic wait_done(input int port, input int n, input int budget, input string tag);
    int k = 0;
    while (done_cnt[port] < n && k < budget) begin
      step();
      k++;
    end
    repeat (3) step();
    chk({tag, "_done_cnt"}, done_cnt[port], n);
  endtask

  task automatic chk_ar(input int idx, input logic [AW-1:0] addr, input logic [7:0] len,
                        input string tag);
    if (idx < ar_addr_q.size()) begin
      chk({tag, "_araddr"}, ar_addr_q[idx], addr);
      chk({tag, "_arlen"},  ar_len_q[idx],  len);
    end else begin
      chk({tag, "_ar_missing"}, ar_addr_q.size(), idx + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int b0;
    req_left[0] = 0; req_left[1] = 0;
    q_sel[0] = '0; q_sel[1] = '0; q_bytes[0] = '0; q_bytes[1] = '0;
    ar_hold = 0; r_left = 0; ar_wait = 1'b0;
    ar_ref_addr = '0; ar_ref_len = '0;
    grant_cyc = 0; last_cyc = 0; done_cyc = 0;
    clear_logs();
    bus.i_port0_rd_queue = '0; bus.i_port0_rd_byte = '0; bus.i_port0_rd_valid = 1'b0;
    bus.i_port1_rd_queue = '0; bus.i_port1_rd_byte = '0; bus.i_port1_rd_valid = 1'b0;
    bus.i_m_axi_arready = 1'b0; bus.i_m_axi_rvalid = 1'b0; bus.i_m_axi_rlast = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (bus.i_port0_rd_valid && bus.o_port0_rd_ready) begin
          grant_q.push_back(0); grant_cyc = cyc;
          if (req_left[0] > 0) req_left[0]--;
        end
        if (bus.i_port1_rd_valid && bus.o_port1_rd_ready) begin
          grant_q.push_back(1); grant_cyc = cyc;
          if (req_left[1] > 0) req_left[1]--;
        end
        if (bus.o_m_axi_arvalid) begin
          arvalid_seen++;
          if (ar_wait && (bus.o_m_axi_araddr !== ar_ref_addr || bus.o_m_axi_arlen !== ar_ref_len))
            ar_unstable++;
          ar_ref_addr = bus.o_m_axi_araddr;
          ar_ref_len  = bus.o_m_axi_arlen;
          if (bus.i_m_axi_arready) begin
            ar_addr_q.push_back(bus.o_m_axi_araddr);
            ar_len_q.push_back(bus.o_m_axi_arlen);
            r_left  = int'(bus.o_m_axi_arlen) + 1;
            ar_wait = 1'b0;
          end else begin
            ar_stall++;
            ar_wait = 1'b1;
          end
        end else begin
          ar_wait = 1'b0;
        end
        if (bus.i_m_axi_rvalid && bus.o_m_axi_rready) begin
          beats_rcvd++;
          if (r_left > 0) r_left--;
          if (bus.i_m_axi_rlast) last_cyc = cyc;
        end
        if (bus.o_port0_rd_done) begin done_cnt[0]++; done_cyc = cyc; end
        if (bus.o_port1_rd_done) begin done_cnt[1]++; done_cyc = cyc; end

        @(posedge clk);
        cyc++;
        #1;
        bus.i_port0_rd_valid = (req_left[0] > 0);
        bus.i_port0_rd_queue = q_sel[0];
        bus.i_port0_rd_byte  = q_bytes[0];
        bus.i_port1_rd_valid = (req_left[1] > 0);
        bus.i_port1_rd_queue = q_sel[1];
        bus.i_port1_rd_byte  = q_bytes[1];
        bus.i_m_axi_arready  = (ar_hold == 0);
        if (bus.o_m_axi_arvalid && ar_hold > 0) ar_hold--;
        bus.i_m_axi_rvalid   = (r_left > 0);
        bus.i_m_axi_rlast    = (r_left == 1);
      end
    join_none

    // Reset: a pending port0 request must not be granted while reset is high.
    issue(0, 4'b0010, 32'd256);
    repeat (3) step();
    chk("rst_busy",    bus.o_rd_busy, 0);
    chk("rst_arvalid", bus.o_m_axi_arvalid, 0);
    chk("rst_araddr",  bus.o_m_axi_araddr, 0);
    chk("rst_arlen",   bus.o_m_axi_arlen, 0);
    chk("rst_rready",  bus.o_m_axi_rready, 0);
    chk("rst_ready0",  bus.o_port0_rd_ready, 0);
    chk("rst_done0",   bus.o_port0_rd_done, 0);
    chk("rst_owner",   bus.o_rd_owner, 0);
    rst = 1'b0;

    // Single 256-byte read on queue 1.
    wait_done(0, 1, 200, "t1");
    chk("t1_ar_count", ar_addr_q.size(), 1);
    chk_ar(0, 32'h0010_0000, 8'd3, "t1");
    chk("t1_beats", beats_rcvd, 4);
    chk("t1_done_after_rlast", done_cyc - last_cyc, 1);
    chk("t1_grants", grant_q.size(), 1);

    clear_logs();
    issue(0, 4'b0010, 32'd64);
    wait_done(0, 1, 100, "t1b");
    chk_ar(0, 32'h0010_0100, 8'd0, "t1b");

    // Lowest set bit selects queue 2; 100 bytes round up to 2 beats.
    clear_logs();
    issue(1, 4'b1100, 32'd100);
    wait_done(1, 1, 100, "t1c");
    chk_ar(0, 32'h0020_0000, 8'd1, "t1c");

    // 9000 bytes on queue 0 split at 4 KB / max-burst.
    clear_logs();
    issue(1, 4'b0000, 32'd9000);
    k = 0;
    while (arvalid_seen == 0 && k < 50) begin step(); k++; end
    chk("t2_owner", bus.o_rd_owner, 1);
    chk("t2_busy",  bus.o_rd_busy, 1);
    wait_done(1, 1, 500, "t2");
    chk("t2_ar_count", ar_addr_q.size(), 3);
    chk_ar(0, 32'h0000_0000, 8'd63, "t2_b0");
    chk_ar(1, 32'h0000_1000, 8'd63, "t2_b1");
    chk_ar(2, 32'h0000_2000, 8'd12, "t2_b2");
    chk("t2_beats", beats_rcvd, 141);
    chk("t2_port0_done", done_cnt[0], 0);

    // Fairness: both ports continuously valid for 4 requests each.
    clear_logs();
    q_sel[0] = 4'b0100; q_bytes[0] = 32'd64;
    q_sel[1] = 4'b1000; q_bytes[1] = 32'd64;
    req_left[0] = 4; req_left[1] = 4;
    k = 0;
    while ((done_cnt[0] < 4 || done_cnt[1] < 4) && k < 400) begin step(); k++; end
    repeat (3) step();
    chk("t3_grant_count", grant_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_q.size()) chk($sformatf("t3_grant%0d", i), grant_q[i], i % 2);
    end

    // Zero-byte request.
    clear_logs();
    issue(0, 4'b0001, 32'd0);
    wait_done(0, 1, 50, "t4");
    chk("t4_done_after_grant", done_cyc - grant_cyc, 2);
    chk("t4_no_arvalid", arvalid_seen, 0);

    // arready low for 10 cycles; queue 0 pointer is 0x2340 after the 9000-byte read.
    clear_logs();
    ar_hold = 10;
    issue(1, 4'b0001, 32'd128);
    wait_done(1, 1, 100, "t5");
    chk("t5_stall", ar_stall, 10);
    chk("t5_unstable", ar_unstable, 0);
    chk_ar(0, 32'h0000_2340, 8'd1, "t5");

    // Reset during DATA after two of four beats.
    clear_logs();
    issue(0, 4'b0001, 32'd256);
    k = 0;
    while (beats_rcvd < 2 && k < 50) begin step(); k++; end
    chk_ar(0, 32'h0000_23C0, 8'd3, "t6");
    rst = 1'b1;
    step();
    chk("t6_busy",    bus.o_rd_busy, 0);
    chk("t6_rready",  bus.o_m_axi_rready, 0);
    chk("t6_arvalid", bus.o_m_axi_arvalid, 0);
    chk("t6_owner",   bus.o_rd_owner, 0);
    chk("t6_done0",   bus.o_port0_rd_done, 0);
    rst = 1'b0;
    b0 = beats_rcvd;
    repeat (6) step();
    chk("t6_ignored_beats", beats_rcvd, b0);
    chk("t6_no_done", done_cnt[0], 0);
    r_left = 0;
    step();

    // Walk queue 0 pointer up to 0xFFFC0, then read across the span end.
    clear_logs();
    issue(0, 4'b0001, 32'h000F_FFC0);
    wait_done(0, 1, 20000, "t7pre");
    chk("t7pre_ar_count", ar_addr_q.size(), 256);
    chk_ar(255, 32'h000F_F000, 8'd62, "t7pre_last");

    clear_logs();
    issue(0, 4'b0001, 32'd512);
    wait_done(0, 1, 100, "t7");
    chk("t7_ar_count", ar_addr_q.size(), 2);
    chk_ar(0, 32'h000F_FFC0, 8'd0, "t7_b0");
    chk_ar(1, 32'h0000_0000, 8'd6, "t7_b1");

    clear_logs();
    issue(0, 4'b0001, 32'd64);
    wait_done(0, 1, 100, "t7ptr");
    chk_ar(0, 32'h0000_01C0, 8'd0, "t7ptr");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
